// File: rtl/fpm_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the FP multiplier arbiter.
// rr_pick is purely combinational; callers zero-extend their request vectors to RR_N_MAX.
package fpm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FP_W     = 32;
  localparam int RR_N_MAX = 32;

  // One-hot grant for the first set bit of valid at or above ptr, wrapping at n.
  function automatic logic [RR_N_MAX-1:0] rr_pick(
    input logic [RR_N_MAX-1:0] valid,
    input logic [4:0]          ptr,
    input logic [5:0]          n
  );
    logic [RR_N_MAX-1:0] grant;
    logic                found;
    logic [5:0]          idx;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < RR_N_MAX; i++) begin
      idx = {1'b0, ptr} + 6'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (6'(i) < n) && valid[idx[4:0]]) begin
        grant[idx[4:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// Requester and response channels of the shared FP multiplier.
// master = requesters/consumer side, slave = arbiter side.
interface fp_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) ();
  import fpm_arb_pkg::*;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [FP_W-1:0]       resp_result;
  logic                  resp_overflow;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_overflow
  );

endinterface

// File: rtl/floating_point_multiplier.sv
// Combinational IEEE-754 single multiply, round-to-nearest-even, subnormals flushed to zero.
// overflow flags a finite product whose exponent exceeds the format (result is signed infinity).
module floating_point_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow
);

  logic        sa, sb, sign;
  logic [7:0]  ea, eb, exp8;
  logic [22:0] fa, fb, mant;
  logic [47:0] prod;
  logic [23:0] mant_r;
  logic [9:0]  exp_u;
  logic        norm, guard, sticky, rnd;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign prod = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    sign     = sa ^ sb;
    a_zero   = (ea == 8'd0);
    b_zero   = (eb == 8'd0);
    a_inf    = (ea == 8'hFF) && (fa == 23'd0);
    b_inf    = (eb == 8'hFF) && (fb == 23'd0);
    a_nan    = (ea == 8'hFF) && (fa != 23'd0);
    b_nan    = (eb == 8'hFF) && (fb != 23'd0);
    norm     = prod[47];
    if (norm) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, rnd};
    // Biased sum before removing 127; kept wide so range checks see the true value.
    exp_u  = {2'b0, ea} + {2'b0, eb} + {9'd0, norm} + {9'd0, mant_r[23]};
    exp8   = ea + eb + {7'd0, norm} + {7'd0, mant_r[23]} + 8'd129;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      result = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      result = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      result = {sign, 31'd0};
    end else if (exp_u >= 10'd382) begin
      result   = {sign, 8'hFF, 23'd0};
      overflow = 1'b1;
    end else if (exp_u <= 10'd127) begin
      result = {sign, 31'd0};
    end else begin
      result = {sign, exp8, mant_r[22:0]};
    end
  end

endmodule

// File: rtl/fpm_rr_arbiter.sv
// Combinational round-robin grant starting at rr_ptr; zero latency, no state.
// The pointer itself is owned and advanced by the parent.
module fpm_rr_arbiter
  import fpm_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic             grant_vld,
  output logic [ID_W-1:0]  grant_idx
);

  logic [RR_N_MAX-1:0] pick;

  assign pick      = rr_pick(RR_N_MAX'(req_valid), 5'(rr_ptr), 6'(N_REQ));
  assign grant     = pick[N_REQ-1:0];
  assign grant_vld = |pick;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin share of one combinational FP multiplier; result MULT_CYCLES clocks after accept,
// response held until resp_ready. Define FPM_ARB_STATS_EN for op_count/ovf_count outputs.
module fp_mult_arbiter
  import fpm_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int MULT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_mult_arbiter_if.slave      bus,
`ifdef FPM_ARB_STATS_EN
  output logic [31:0]           op_count,
  output logic [15:0]           ovf_count,
`endif
  output logic                  busy
);

  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

  generate
    if (MULT_CYCLES < 1) begin : g_bad_cycles
      $error("fp_mult_arbiter: MULT_CYCLES must be >= 1");
    end
    if (N_REQ < 2 || N_REQ > RR_N_MAX) begin : g_bad_nreq
      $error("fp_mult_arbiter: N_REQ out of range");
    end
    if (ID_W != $clog2(N_REQ)) begin : g_bad_idw
      $error("fp_mult_arbiter: ID_W must equal clog2(N_REQ)");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, id_q, resp_id_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [FP_W-1:0]   a_q, b_q, sel_a, sel_b, mult_res, res_q;
  logic              mult_ovf, ovf_q;
  logic [N_REQ-1:0]  grant;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic              accept, capture, resp_hs;

  fpm_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Operands come only from the registers, giving the multiplier a MULT_CYCLES path.
  floating_point_multiplier u_mult (
    .a        (a_q),
    .b        (b_q),
    .result   (mult_res),
    .overflow (mult_ovf)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*FP_W +: FP_W];
        sel_b = bus.req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    resp_hs = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_hs = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      resp_id_q <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept) begin
        a_q      <= sel_a;
        b_q      <= sel_b;
        id_q     <= grant_idx;
        rr_ptr_q <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        cnt_q    <= CNT_W'(MULT_CYCLES - 1);
      end else if (state_q == EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        res_q     <= mult_res;
        ovf_q     <= mult_ovf;
        resp_id_q <= id_q;
      end
    end
  end

  // Gated by rst so req_ready reads zero while reset is held, even with requests pending.
  assign bus.req_ready     = (state_q == IDLE && rst) ? grant : '0;
  assign bus.resp_valid    = (state_q == RESP);
  assign bus.resp_id       = resp_id_q;
  assign bus.resp_result   = res_q;
  assign bus.resp_overflow = ovf_q;
  assign busy              = (state_q != IDLE);

`ifdef FPM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (resp_hs) begin
      op_count <= op_count + 1'b1;
      if (ovf_q && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 1'b1;
    end
  end
`endif

endmodule
